// File: rtl/lc4_seq_divider_pkg.sv
// Shared definitions for the LC4 sequential divider: state encodings and iteration sizing.
package lc4_seq_divider_pkg;

  localparam int unsigned DIV_W     = 16;
  localparam int unsigned DIV_ITERS = 16;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a group-carry chain.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [2:0]  gg;
  logic [2:0]  gp;
  logic [3:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    // group generate/propagate; the top group never feeds a carry onward
    for (int k = 0; k < 3; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int k = 0; k < 3; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
    s = p ^ c;
  end

endmodule

// File: rtl/lc4_seq_divider.sv
// Multi-cycle restoring 16-bit unsigned divider (LC4 DIV/MOD), one quotient bit per clock.
module lc4_seq_divider
  import lc4_seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  // The subtractor is a fixed 16-bit cla16, so no other width can work.
  if (WIDTH != DIV_W) begin : g_width_check
    $error("lc4_seq_divider supports only WIDTH=16");
  end

  div_state_e       state;
  div_state_e       state_nxt;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] count_q;

  logic             accept_c;
  logic             last_iter_c;
  logic             msb_c;
  logic [WIDTH-1:0] sh_c;
  logic [WIDTH-1:0] nb_c;
  logic [WIDTH-1:0] diff_c;
  logic             c15_c;
  logic             cout_c;
  logic             take_c;
  logic [WIDTH-1:0] rem_nxt_c;
  logic [WIDTH-1:0] quo_nxt_c;

  assign o_ready     = (state == S_IDLE);
  assign o_valid     = (state == S_DONE);
  assign accept_c    = i_valid & o_ready;
  assign last_iter_c = (count_q == CNT_W'(DIV_ITERS - 1));

  // Trial subtraction sh - divisor as sh + ~divisor + 1.
  cla16 u_sub (
    .a   (sh_c),
    .b   (nb_c),
    .cin (1'b1),
    .s   (diff_c)
  );

  // One restoring step; carry-out is rebuilt from bit 15 since cla16 does not export it.
  always_comb begin
    msb_c     = rem_q[WIDTH-1];
    sh_c      = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    nb_c      = ~divisor_q;
    c15_c     = diff_c[WIDTH-1] ^ sh_c[WIDTH-1] ^ nb_c[WIDTH-1];
    cout_c    = (sh_c[WIDTH-1] & nb_c[WIDTH-1]) | ((sh_c[WIDTH-1] | nb_c[WIDTH-1]) & c15_c);
    take_c    = msb_c | cout_c;
    rem_nxt_c = take_c ? diff_c : sh_c;
    quo_nxt_c = {quo_q[WIDTH-2:0], take_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          state_nxt = (i_divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter_c) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in RUN, publish results on the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      count_q     <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else if (accept_c) begin
      divisor_q <= i_divisor;
      rem_q     <= '0;
      quo_q     <= i_dividend;
      count_q   <= '0;
      if (i_divisor == '0) begin
        o_quotient  <= '0;
        o_remainder <= '0;
      end
    end else if (state == S_RUN) begin
      rem_q   <= rem_nxt_c;
      quo_q   <= quo_nxt_c;
      count_q <= CNT_W'(count_q + CNT_W'(1));
      if (last_iter_c) begin
        o_quotient  <= quo_nxt_c;
        o_remainder <= rem_nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_lc4_seq_divider.sv
// Self-checking bench for lc4_seq_divider: directed corner cases plus a random scoreboard.
module tb_lc4_seq_divider;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_valid;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  int checks = 0;
  int errors = 0;

  lc4_seq_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_valid     (o_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: LC4 defines x/0 and x%0 as 0; nonzero divisors take 16 iterations plus DONE.
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'd0 : 16'(a / b);
  endfunction

  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'd0 : 16'(a % b);
  endfunction

  function automatic int ref_lat(input logic [15:0] b);
    return (b == 16'd0) ? 1 : 17;
  endfunction

  // Called just after a negedge while idle; returns at the negedge following the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    check("ready_before_accept", 32'(o_ready), 32'd1);
    i_valid    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    @(negedge clk);
    i_valid    = 1'b0;
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
  endtask

  // Counts cycles from the accept edge until o_valid, then checks data and pulse width.
  task automatic wait_result(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n = 1;
    while (!o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(ref_lat(b)));
    check({tag, "_quotient"}, 32'(o_quotient), 32'(ref_q(a, b)));
    check({tag, "_remainder"}, 32'(o_remainder), 32'(ref_r(a, b)));
    @(negedge clk);
    check({tag, "_valid_width"}, 32'(o_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(o_ready), 32'd1);
    check({tag, "_held_q"}, 32'(o_quotient), 32'(ref_q(a, b)));
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b);
    issue(a, b);
    wait_result(tag, a, b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    logic [15:0] a;
    logic [15:0] b;

    rst        = 1'b1;
    i_valid    = 1'b0;
    i_dividend = 16'd0;
    i_divisor  = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_quotient", 32'(o_quotient), 32'd0);
    check("rst_remainder", 32'(o_remainder), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("ffff_div_1", 16'hFFFF, 16'h0001);
    run_div("100_div_7", 16'd100, 16'd7);
    run_div("5_div_9", 16'h0005, 16'h0009);
    run_div("div_by_zero", 16'h1234, 16'h0000);
    run_div("ffff_div_8001", 16'hFFFF, 16'h8001);
    run_div("8000_div_ffff", 16'h8000, 16'hFFFF);

    // Asynchronous reset in the middle of a RUN, away from any clock edge.
    issue(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_quotient", 32'(o_quotient), 32'd0);
    check("abort_remainder", 32'(o_remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    check("abort_no_valid", 32'(pulses), 32'd0);
    run_div("1000_div_3", 16'd1000, 16'd3);

    // Request held during RUN must not disturb the current op and is taken once idle.
    issue(16'd50, 16'd5);
    i_valid    = 1'b1;
    i_dividend = 16'd7;
    i_divisor  = 16'd2;
    wait_result("50_div_5_busy", 16'd50, 16'd5);
    @(negedge clk);
    i_valid = 1'b0;
    wait_result("7_div_2_held", 16'd7, 16'd2);

    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = {1'b1, 15'($urandom)};
        3:       begin b = 16'($urandom); a = 16'hFFFF; end
        default: b = 16'($urandom);
      endcase
      run_div("random", a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
